// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_pkg
// Brief  : Shared constants, op codes and state encodings for the EX-stage
//          iterative multiply/divide unit.
// Rev    : 1.0
// ============================================================================
package ex_muldiv_pkg;

    localparam int XLEN    = 32;
    localparam int ITER    = 32;
    localparam int c_CNT_W = $clog2(ITER);

    localparam logic [1:0] c_OP_MULT  = 2'b00;
    localparam logic [1:0] c_OP_MULTU = 2'b01;
    localparam logic [1:0] c_OP_DIV   = 2'b10;
    localparam logic [1:0] c_OP_DIVU  = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CALC  = 2'd1;
    localparam logic [1:0] c_ST_FIXUP = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_step
// Brief  : One iteration of shift-add multiply or restoring divide.
// Rev    : 1.0
// ============================================================================
module ex_muldiv_step
    import ex_muldiv_pkg::*;
(
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_add;
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    always_comb begin
        w_add   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
        w_shift = {i_hi, i_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_b};
        // Explicit compare rather than borrow bit: the shifted remainder can use bit XLEN
        w_ge    = (w_shift >= {1'b0, i_b});
        o_hi    = w_add[XLEN:1];
        o_lo    = {w_add[0], i_lo[XLEN-1:1]};
        if (i_is_div) begin
            if (w_ge) begin
                o_hi = w_diff[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b1};
            end else begin
                o_hi = w_shift[XLEN-1:0];
                o_lo = {i_lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ex_muldiv_ctrl
// Brief  : EX-stage multi-cycle MULT/MULTU/DIV/DIVU controller with HI/LO.
// Rev    : 1.0
// ============================================================================
module ex_muldiv_ctrl #(
    parameter int XLEN = ex_muldiv_pkg::XLEN,
    parameter int ITER = ex_muldiv_pkg::ITER
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start_EX,
    input  logic [1:0]      MulDiv_Op_EX,
    input  logic [XLEN-1:0] Read_Data_1_EX,
    input  logic [XLEN-1:0] Read_Data_2_EX,
    input  logic            Flush_EX,
    input  logic            Read_HiLo_EX,
    output logic [XLEN-1:0] HI_EX,
    output logic [XLEN-1:0] LO_EX,
    output logic            Busy_EX,
    output logic            Done_EX,
    output logic            Stall_EX
);

    import ex_muldiv_pkg::*;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(ITER - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_div_zero;
    logic               r_done;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_acc_hi;
    logic [XLEN-1:0]    r_acc_lo;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;

    logic [XLEN-1:0]    w_step_hi;
    logic [XLEN-1:0]    w_step_lo;
    logic [2*XLEN-1:0]  w_prod_neg;
    logic               w_signed;

    ex_muldiv_step u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_b      (r_b),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    assign w_signed   = op_is_signed(MulDiv_Op_EX);
    assign w_prod_neg = -{r_acc_hi, r_acc_lo};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
            r_b        <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else if (Flush_EX) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (Start_EX) begin
                        r_state    <= c_ST_CALC;
                        r_count    <= '0;
                        r_is_div   <= op_is_div(MulDiv_Op_EX);
                        r_sign_a   <= w_signed & Read_Data_1_EX[XLEN-1];
                        r_sign_b   <= w_signed & Read_Data_2_EX[XLEN-1];
                        r_div_zero <= op_is_div(MulDiv_Op_EX) & (Read_Data_2_EX == '0);
                        r_b        <= w_signed ? abs_val(Read_Data_2_EX) : Read_Data_2_EX;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_signed ? abs_val(Read_Data_1_EX) : Read_Data_1_EX;
                    end
                end
                c_ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_count  <= r_count + 1'b1;
                    if (r_count == c_CNT_LAST) begin
                        r_state <= c_ST_FIXUP;
                    end
                end
                c_ST_FIXUP: begin
                    r_state <= c_ST_DONE;
                    if (!r_is_div) begin
                        if (r_sign_a ^ r_sign_b) begin
                            {r_acc_hi, r_acc_lo} <= w_prod_neg;
                        end
                    end else begin
                        // Remainder follows the dividend; divide by zero forces an all-ones quotient
                        if (r_sign_a) begin
                            r_acc_hi <= -r_acc_hi;
                        end
                        if (r_div_zero) begin
                            r_acc_lo <= '1;
                        end else if (r_sign_a ^ r_sign_b) begin
                            r_acc_lo <= -r_acc_lo;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (!r_done) begin
                        r_hi   <= r_acc_hi;
                        r_lo   <= r_acc_lo;
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign HI_EX    = r_hi;
    assign LO_EX    = r_lo;
    assign Busy_EX  = (r_state != c_ST_IDLE);
    assign Done_EX  = r_done;
    assign Stall_EX = Busy_EX & (Start_EX | Read_HiLo_EX);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_muldiv_ctrl
// Brief  : Directed-vector self-checking bench for ex_muldiv_ctrl.
// Rev    : 1.0
// ============================================================================
module tb_ex_muldiv_ctrl;

    localparam logic [1:0] c_MULT  = 2'b00;
    localparam logic [1:0] c_MULTU = 2'b01;
    localparam logic [1:0] c_DIV   = 2'b10;
    localparam logic [1:0] c_DIVU  = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start_EX;
    logic [1:0]  MulDiv_Op_EX;
    logic [31:0] Read_Data_1_EX;
    logic [31:0] Read_Data_2_EX;
    logic        Flush_EX;
    logic        Read_HiLo_EX;
    logic [31:0] HI_EX;
    logic [31:0] LO_EX;
    logic        Busy_EX;
    logic        Done_EX;
    logic        Stall_EX;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    ex_muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start_EX       (Start_EX),
        .MulDiv_Op_EX   (MulDiv_Op_EX),
        .Read_Data_1_EX (Read_Data_1_EX),
        .Read_Data_2_EX (Read_Data_2_EX),
        .Flush_EX       (Flush_EX),
        .Read_HiLo_EX   (Read_HiLo_EX),
        .HI_EX          (HI_EX),
        .LO_EX          (LO_EX),
        .Busy_EX        (Busy_EX),
        .Done_EX        (Done_EX),
        .Stall_EX       (Stall_EX)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns one step after edge 0 (the accepting edge)
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start_EX       = 1'b1;
        MulDiv_Op_EX   = op;
        Read_Data_1_EX = a;
        Read_Data_2_EX = b;
        @(posedge Clk);
        #1;
        Start_EX = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int elapsed,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        lat = -1;
        for (int i = elapsed + 1; i <= elapsed + 60; i++) begin
            @(posedge Clk);
            #1;
            if (Done_EX) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 34);
        check({tag, "_hi"}, HI_EX, exp_hi);
        check({tag, "_lo"}, LO_EX, exp_lo);
        check({tag, "_busy_at_done"}, {31'd0, Busy_EX}, 32'd1);
        @(posedge Clk);
        #1;
        check({tag, "_done_one_cycle"}, {31'd0, Done_EX}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, Busy_EX}, 32'd0);
    endtask

    initial begin
        int done_seen;
        Reset          = 1'b1;
        Start_EX       = 1'b0;
        MulDiv_Op_EX   = 2'b00;
        Read_Data_1_EX = '0;
        Read_Data_2_EX = '0;
        Flush_EX       = 1'b0;
        Read_HiLo_EX   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_hi", HI_EX, 32'h0);
        check("rst_lo", LO_EX, 32'h0);
        check("rst_busy", {31'd0, Busy_EX}, 32'd0);
        check("rst_done", {31'd0, Done_EX}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        Read_HiLo_EX = 1'b1;
        #1;
        check("idle_no_stall", {31'd0, Stall_EX}, 32'd0);
        Read_HiLo_EX = 1'b0;
        @(posedge Clk);
        #1;

        start_op(c_MULT, 32'd7, 32'hFFFF_FFFD);
        finish_op("mult_7xm3", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        start_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001);
        start_op(c_MULT, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("mult_min_xm1", 0, 32'h0000_0000, 32'h8000_0000);
        start_op(c_DIVU, 32'd100, 32'd7);
        finish_op("divu_100_7", 0, 32'd2, 32'd14);
        start_op(c_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7_2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(c_DIV, 32'd7, 32'hFFFF_FFFE);
        finish_op("div_7_m2", 0, 32'd1, 32'hFFFF_FFFD);
        start_op(c_DIVU, 32'h1234_5678, 32'd0);
        finish_op("divu_by0", 0, 32'h1234_5678, 32'hFFFF_FFFF);
        start_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 0, 32'h0, 32'h8000_0000);

        // Second start and HI/LO read while busy
        start_op(c_MULTU, 32'd3, 32'd5);
        repeat (5) begin
            @(posedge Clk);
            #1;
        end
        Start_EX       = 1'b1;
        MulDiv_Op_EX   = c_DIVU;
        Read_Data_1_EX = 32'd100;
        Read_Data_2_EX = 32'd7;
        Read_HiLo_EX   = 1'b1;
        #1;
        check("stall_busy_start", {31'd0, Stall_EX}, 32'd1);
        @(posedge Clk);
        #1;
        Start_EX = 1'b0;
        #1;
        check("stall_busy_read", {31'd0, Stall_EX}, 32'd1);
        Read_HiLo_EX = 1'b0;
        #1;
        check("stall_released", {31'd0, Stall_EX}, 32'd0);
        finish_op("stall_first_only", 6, 32'd0, 32'd15);

        // Flush in CALC
        start_op(c_MULTU, 32'd16, 32'd16);
        repeat (10) begin
            @(posedge Clk);
            #1;
        end
        Flush_EX = 1'b1;
        @(posedge Clk);
        #1;
        Flush_EX = 1'b0;
        check("flush_idle", {31'd0, Busy_EX}, 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge Clk);
            #1;
            if (Done_EX) done_seen++;
        end
        check("flush_no_done", done_seen, 32'd0);
        check("flush_hi_kept", HI_EX, 32'd0);
        check("flush_lo_kept", LO_EX, 32'd15);

        // Flush wins over Start in IDLE
        Flush_EX       = 1'b1;
        Start_EX       = 1'b1;
        MulDiv_Op_EX   = c_MULTU;
        Read_Data_1_EX = 32'd2;
        Read_Data_2_EX = 32'd2;
        @(posedge Clk);
        #1;
        Flush_EX = 1'b0;
        Start_EX = 1'b0;
        check("flush_prio_idle", {31'd0, Busy_EX}, 32'd0);

        // Asynchronous reset mid-operation
        start_op(c_MULTU, 32'd9, 32'd9);
        repeat (20) begin
            @(posedge Clk);
            #1;
        end
        check("pre_reset_busy", {31'd0, Busy_EX}, 32'd1);
        Reset = 1'b1;
        #1;
        check("arst_hi", HI_EX, 32'h0);
        check("arst_lo", LO_EX, 32'h0);
        check("arst_busy", {31'd0, Busy_EX}, 32'd0);
        check("arst_done", {31'd0, Done_EX}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        start_op(c_MULT, 32'd7, 32'hFFFF_FFFD);
        finish_op("post_reset_mult", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_ctrl.md
EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: ITER, 32, iteration cycles per operation; fixed equal to XLEN.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start_EX  input  1  request to launch an operation; sampled on the rising edge.
REQ-006 MulDiv_Op_EX  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 Read_Data_1_EX  input  32  operand A (multiplicand/dividend).
REQ-008 Read_Data_2_EX  input  32  operand B (multiplier/divisor).
REQ-009 Flush_EX  input  1  abort any in-flight operation without writing HI/LO.
REQ-010 Read_HiLo_EX  input  1  MFHI/MFLO read request from the pipeline.
REQ-011 HI_EX  output  32  architectural HI register.
REQ-012 LO_EX  output  32  architectural LO register.
REQ-013 Busy_EX  output  1  high whenever state is not IDLE.
REQ-014 Done_EX  output  1  one-cycle pulse when HI/LO are updated.
REQ-015 Stall_EX  output  1  pipeline hold request (combinational).

Function
REQ-016 States SHALL be IDLE, CALC, FIXUP and DONE.
REQ-017 IDLE -> CALC SHALL occur when Start_EX=1 and Flush_EX=0, latching operands, op and operand signs, and clearing the iteration counter.
REQ-018 Signed ops SHALL latch absolute operand values; unsigned ops SHALL latch raw values.
REQ-019 CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle for exactly 32 cycles, then go to FIXUP.
REQ-020 FIXUP SHALL apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the sign of the dividend.
REQ-021 DONE SHALL write HI/LO, pulse Done_EX for one cycle and return to IDLE.
REQ-022 Latency: with Start_EX accepted at edge 0, HI/LO SHALL be updated and Done_EX high after edge 34, with IDLE reached at edge 35.
REQ-023 MULT/MULTU SHALL write product[63:32] to HI and product[31:0] to LO.
REQ-024 DIV/DIVU SHALL write the quotient to LO and the remainder to HI.
REQ-025 On divide by zero, LO SHALL be 0xFFFFFFFF and HI SHALL equal operand A; no exception is raised.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-027 Start_EX while Busy_EX=1 SHALL be ignored, with Stall_EX asserted for that cycle.
REQ-028 Stall_EX SHALL equal Busy_EX & (Start_EX | Read_HiLo_EX).
REQ-029 Flush_EX in any state SHALL force IDLE on the next edge without writing HI/LO or pulsing Done_EX.
REQ-030 If Flush_EX and Start_EX are both high in IDLE, the flush SHALL take priority and no operation starts.
REQ-031 HI_EX/LO_EX SHALL hold their values at all times except in the DONE write and on reset.

Reset
REQ-032 Reset SHALL asynchronously force state IDLE, HI_EX=0, LO_EX=0, Busy_EX=0, Done_EX=0, counter=0 and the internal operand/accumulator registers to 0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no partial HI/LO write; the first operation after deassertion SHALL behave as if from power-up.

Structure
REQ-034 Op codes, state encodings and the constants XLEN/ITER SHALL live in the shared package ex_muldiv_pkg.
REQ-035 The per-cycle shift-add/subtract step SHALL be the single combinational sub-module ex_muldiv_step; counter, FSM and HI/LO registers remain in ex_muldiv_ctrl.

Verification
REQ-036 MULT A=7, B=0xFFFFFFFD -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB, Done_EX pulsed once.
REQ-037 DIVU A=100, B=7 -> LO=14, HI=2; DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-039 Start an op, then assert Start_EX and Read_HiLo_EX at cycle 5 -> Stall_EX=1 on those cycles, second start ignored, HI/LO reflect only the first op.
REQ-040 Flush_EX at cycle 10 of CALC -> IDLE next cycle, no Done_EX, HI/LO unchanged; repeat with Reset at cycle 20 -> all outputs 0 immediately.
